// File: rtl/t03_fetch_mem_arbiter.sv
// -----------------------------------------------------------------------------
// t03_fetch_mem_arbiter
//
// Single-port memory sequencer sitting in front of the instruction holder and
// the PC. One shared bus is time-multiplexed between instruction fetch and
// data load/store. Each instruction walks IDLE -> FETCH -> DECODE [-> DATA]
// and is retired (freezePC low for one cycle) only once any memory access it
// needs has been acknowledged.
//
// Ports
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   pc            current program counter (byte address) used for fetches
//   load_req      decoded instruction is a load  (sampled in DECODE)
//   store_req     decoded instruction is a store (sampled in DECODE)
//   data_addr     load/store byte address
//   store_data    store write data
//   byte_sel      load/store byte enables
//   bus_rdata     memory read data, valid with bus_ack
//   bus_ack       single-cycle completion strobe of the outstanding request
//   bus_read      read request, held until ack
//   bus_write     write request, held until ack
//   bus_addr      request address
//   bus_wdata     write data (0 unless a store is on the bus)
//   bus_sel       request byte enables
//   dataOut       bus_rdata passed straight through to the instruction holder
//   freezeInstr   low only in the cycle a fetch completes
//   freezePC      low only in the cycle an instruction retires
//   load_data     registered result of the last completed load
// -----------------------------------------------------------------------------
module t03_fetch_mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        load_req,
  input  logic        store_req,
  input  logic [31:0] data_addr,
  input  logic [31:0] store_data,
  input  logic [3:0]  byte_sel,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_read,
  output logic        bus_write,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_sel,
  output logic [31:0] dataOut,
  output logic        freezeInstr,
  output logic        freezePC,
  output logic [31:0] load_data
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_DECODE = 2'd2,
    S_DATA   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // Memory operation latched in DECODE; at most one of the two is ever set.
  logic r_op_load;
  logic r_op_store;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. An ack outside FETCH/DATA has no effect.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:   w_next_state = S_FETCH;
      S_FETCH:  if (bus_ack) w_next_state = S_DECODE;
      S_DECODE: w_next_state = (load_req || store_req) ? S_DATA : S_FETCH;
      S_DATA:   if (bus_ack) w_next_state = S_FETCH;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs. Purely a function of state (and ack for the freeze strobes), so
  // an asynchronous reset drops the request lines immediately.
  // ---------------------------------------------------------------------------
  always_comb begin
    bus_read    = 1'b0;
    bus_write   = 1'b0;
    bus_addr    = 32'h0;
    bus_wdata   = 32'h0;
    bus_sel     = 4'h0;
    freezeInstr = 1'b1;
    freezePC    = 1'b1;
    unique case (r_state)
      S_IDLE: begin
      end
      S_FETCH: begin
        bus_read    = 1'b1;
        bus_addr    = pc;
        bus_sel     = 4'hF;
        // Holder captures bus_rdata on the ack edge.
        freezeInstr = !bus_ack;
      end
      S_DECODE: begin
        // Plain ALU instruction retires here without touching the bus.
        freezePC = load_req || store_req;
      end
      S_DATA: begin
        bus_read  = r_op_load;
        bus_write = r_op_store;
        bus_addr  = data_addr;
        bus_sel   = byte_sel;
        bus_wdata = r_op_store ? store_data : 32'h0;
        freezePC  = !bus_ack;
      end
      default: begin
      end
    endcase
  end

  assign dataOut = bus_rdata;

  // ---------------------------------------------------------------------------
  // Operation latch: load has priority; a simultaneous store is dropped.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op_load  <= 1'b0;
      r_op_store <= 1'b0;
    end else if (r_state == S_DECODE && (load_req || store_req)) begin
      r_op_load  <= load_req;
      r_op_store <= store_req && !load_req;
    end
  end

  // ---------------------------------------------------------------------------
  // Load result register, updated only by an acknowledged load.
  // ---------------------------------------------------------------------------
  // NOTE: load_data is a visible architectural output with a defined reset
  // value, so it is reset even though it is a data register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_data <= 32'h0;
    end else if (r_state == S_DATA && r_op_load && bus_ack) begin
      load_data <= bus_rdata;
    end
  end

endmodule
